// File: rtl/alu_seq16.sv
// Multi-cycle sequencer driving a shared 8-bit ALU: 16-bit add/subtract in two
// carry-chained byte passes, unsigned 8x8 multiply as an 8-step shift-add loop.
`timescale 1ns/1ps
module alu_seq16 #(
    parameter logic [7:0] OP_ADD = 8'h10,
    parameter logic [7:0] OP_ADC = 8'h11,
    parameter logic [7:0] OP_SUB = 8'h12,
    parameter logic [7:0] OP_SBC = 8'h13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        carry,
    output logic        zero,
    output logic        err,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [7:0]  alu_cins,
    output logic        alu_carryin,
    output logic        alu_oe,
    input  logic [7:0]  alu_out,
    input  logic        alu_carryout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_MUL,
        S_DONE
    } state_t;

    state_t      state;
    logic        is_sub;
    logic [15:0] opa_r;
    logic [15:0] opb_r;
    logic        cflag;
    logic [7:0]  acc_hi;
    // acc_lo[0] would be shifted out before it is ever read, so it is not stored.
    logic [7:1]  acc_lo;
    logic [7:0]  mplr;
    logic [3:0]  mcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
            err    <= 1'b0;
            is_sub <= 1'b0;
            opa_r  <= '0;
            opb_r  <= '0;
            cflag  <= 1'b0;
            acc_hi <= '0;
            acc_lo <= '0;
            mplr   <= '0;
            mcnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_sub <= op[0];
                        opa_r  <= opa;
                        opb_r  <= opb;
                        err    <= 1'b0;
                        busy   <= 1'b1;
                        case (op)
                            2'b00, 2'b01: state <= S_LO;
                            2'b10: begin
                                state  <= S_MUL;
                                acc_hi <= '0;
                                acc_lo <= '0;
                                mplr   <= opb[7:0];
                                mcnt   <= '0;
                            end
                            default: begin
                                state  <= S_DONE;
                                result <= '0;
                                carry  <= 1'b0;
                                zero   <= 1'b1;
                                err    <= 1'b1;
                                done   <= 1'b1;
                            end
                        endcase
                    end
                end
                S_LO: begin
                    result[7:0] <= alu_out;
                    cflag       <= alu_carryout;
                    state       <= S_HI;
                end
                S_HI: begin
                    result[15:8] <= alu_out;
                    carry        <= alu_carryout;
                    zero         <= ({alu_out, result[7:0]} == 16'h0000);
                    done         <= 1'b1;
                    state        <= S_DONE;
                end
                S_MUL: begin
                    // 17-bit right shift of {carryout, sum, acc_lo}
                    acc_hi <= {alu_carryout, alu_out[7:1]};
                    acc_lo <= {alu_out[0], acc_lo[7:2]};
                    mplr   <= mplr >> 1;
                    mcnt   <= mcnt + 4'd1;
                    if (mcnt == 4'd7) begin
                        result <= {alu_carryout, alu_out, acc_lo[7:1]};
                        carry  <= 1'b0;
                        zero   <= ({alu_carryout, alu_out, acc_lo[7:1]} == 16'h0000);
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        alu_cins    = '0;
        alu_carryin = 1'b0;
        alu_oe      = 1'b0;
        case (state)
            S_LO: begin
                alu_a    = opa_r[7:0];
                alu_b    = opb_r[7:0];
                alu_cins = is_sub ? OP_SUB : OP_ADD;
                alu_oe   = 1'b1;
            end
            S_HI: begin
                alu_a       = opa_r[15:8];
                alu_b       = opb_r[15:8];
                alu_cins    = is_sub ? OP_SBC : OP_ADC;
                alu_carryin = cflag;
                alu_oe      = 1'b1;
            end
            S_MUL: begin
                alu_a    = acc_hi;
                alu_b    = mplr[0] ? opa_r[7:0] : 8'h00;
                alu_cins = OP_ADD;
                alu_oe   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
